seg7_scan_decoder: RTL and testbench

//  Reader side of the 7-segment display bus: samples a multiplexed segment bus (8 segment lines + one-hot digit enables).

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_pattern_decode.sv | 32 +++
 rtl/seg7_scan_decoder.sv | 168 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment bus reader: segment indices, glyph table and FSM states.
package seg7_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Entry n is the lit-segment pattern for hex digit n, leftmost bit is segment a.
  localparam logic [0:6] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_ACCEPT,
    ST_LOCKED
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup of a seven-segment pattern back to its hex nibble.
// Build option: SEG7_DEC_BLANK_EN treats the all-off pattern as a legal blank.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [0:6] seg,
  output logic       ok,
  output logic [3:0] nibble
`ifdef SEG7_DEC_BLANK_EN
  ,
  output logic       blank
`endif
);

  always_comb begin
    ok     = 1'b0;
    nibble = 4'h0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        ok     = 1'b1;
        nibble = 4'(i);
      end
    end
`ifdef SEG7_DEC_BLANK_EN
    blank = (seg == 7'b0000000);
    if (blank) begin
      ok = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-segment bus and recovers per-digit nibbles with one change event per dwell.
// Build option: SEG7_DEC_BLANK_EN accepts the all-off pattern as a blank digit and adds blank_out.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [0:7]            seg,
  input  logic [N_DIGITS-1:0]   dig_en,
  output logic [4*N_DIGITS-1:0] hex_out,
  output logic [N_DIGITS-1:0]   dp_out,
  output logic [N_DIGITS-1:0]   digit_ok,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [2:0]            evt_digit,
  output logic [3:0]            evt_nibble,
  output logic                  evt_err,
  output logic                  overflow
`ifdef SEG7_DEC_BLANK_EN
  ,
  output logic [N_DIGITS-1:0]   blank_out
`endif
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  logic [0:7]          seg_q, snap_seg_q;
  logic [N_DIGITS-1:0] en_q, snap_en_q;
  logic [CntW-1:0]     cnt_q;
  state_e              state_q;

  logic       en_onehot, same, changed, new_evt, pop;
  logic       dec_ok;
  logic [3:0] dec_nibble;
  logic [2:0] snap_idx;
`ifdef SEG7_DEC_BLANK_EN
  logic       dec_blank;
`endif

  seg7_pattern_decode u_decode (
    .seg    (snap_seg_q[0:6]),
    .ok     (dec_ok),
    .nibble (dec_nibble)
`ifdef SEG7_DEC_BLANK_EN
    ,
    .blank  (dec_blank)
`endif
  );

  always_comb begin
    en_onehot = $onehot(en_q);
    same      = (seg_q == snap_seg_q) && (en_q == snap_en_q);
    snap_idx  = '0;
    changed   = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (snap_en_q[i]) begin
        snap_idx = 3'(i);
        changed  = (hex_out[4*i +: 4] != dec_nibble) || (dp_out[i] != snap_seg_q[SEG_DP]) ||
                   (digit_ok[i] != dec_ok);
      end
    end
    pop     = evt_valid && evt_ready;
    new_evt = (state_q == ST_ACCEPT) && changed;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= '0;
      en_q  <= '0;
    end else begin
      seg_q <= seg;
      en_q  <= dig_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      snap_seg_q <= '0;
      snap_en_q  <= '0;
      hex_out    <= '0;
      dp_out     <= '0;
      digit_ok   <= '0;
      evt_valid  <= 1'b0;
      evt_digit  <= '0;
      evt_nibble <= '0;
      evt_err    <= 1'b0;
      overflow   <= 1'b0;
`ifdef SEG7_DEC_BLANK_EN
      blank_out  <= '0;
`endif
    end else begin
      // Any sample that breaks the current dwell becomes the new reference.
      if (state_q == ST_IDLE || !same) begin
        snap_seg_q <= seg_q;
        snap_en_q  <= en_q;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (en_onehot) begin
            state_q <= ST_TRACK;
            cnt_q   <= CntW'(1);
          end
        end
        ST_TRACK: begin
          if (!en_onehot) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (!same) begin
            cnt_q <= CntW'(1);
          end else if (cnt_q == CntLast) begin
            state_q <= ST_ACCEPT;
            cnt_q   <= cnt_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_ACCEPT, ST_LOCKED: begin
          if (!en_onehot) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (!same) begin
            state_q <= ST_TRACK;
            cnt_q   <= CntW'(1);
          end else begin
            state_q <= ST_LOCKED;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (state_q == ST_ACCEPT) begin
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
          if (snap_en_q[i]) begin
            hex_out[4*i +: 4] <= dec_nibble;
            dp_out[i]         <= snap_seg_q[SEG_DP];
            digit_ok[i]       <= dec_ok;
`ifdef SEG7_DEC_BLANK_EN
            blank_out[i]      <= dec_blank;
`endif
          end
        end
      end

      if (pop) begin
        evt_valid <= 1'b0;
      end
      // A slot freed by this cycle's handshake may be refilled immediately.
      if (new_evt) begin
        if (!evt_valid || pop) begin
          evt_valid  <= 1'b1;
          evt_digit  <= snap_idx;
          evt_nibble <= dec_nibble;
          evt_err    <= !dec_ok;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: run-length reference model compared every cycle plus literal checks.
module tb_seg7_scan_decoder;

  localparam int N = 4;
  localparam int S = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [0:7]     seg = '0;
  logic [N-1:0]   dig_en = '0;
  logic           evt_ready = 1'b1;
  logic [4*N-1:0] hex_out;
  logic [N-1:0]   dp_out;
  logic [N-1:0]   digit_ok;
  logic           evt_valid;
  logic [2:0]     evt_digit;
  logic [3:0]     evt_nibble;
  logic           evt_err;
  logic           overflow;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .N_DIGITS      (N),
    .STABLE_CYCLES (S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .dig_en     (dig_en),
    .hex_out    (hex_out),
    .dp_out     (dp_out),
    .digit_ok   (digit_ok),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_digit  (evt_digit),
    .evt_nibble (evt_nibble),
    .evt_err    (evt_err),
    .overflow   (overflow)
  );

  logic [6:0] pat_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    int         dig;
    logic [6:0] pat;
    logic       dp;
  } acc_t;

  acc_t         pend[$];
  logic [3:0]   m_hex [N];
  logic [N-1:0] m_dp, m_ok;
  logic         m_valid, m_err, m_ovf;
  logic [2:0]   m_digit;
  logic [3:0]   m_nib;
  logic [N-1:0] prev_en;
  logic [0:7]   prev_seg;
  int           run = 0;
  int           cyc = 0;
  int           dut_evts = 0;
  bit           armed = 0;

  function automatic logic [4:0] decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (p == pat_tab[i]) return {1'b1, 4'(i)};
    return 5'b0;
  endfunction

  always @(posedge clk) begin
    if (evt_valid && evt_ready) dut_evts++;
    cyc++;
    if (!rst_n) begin
      armed = 1;
      pend.delete();
      for (int i = 0; i < N; i++) m_hex[i] = 4'h0;
      m_dp = '0; m_ok = '0; m_valid = 0; m_err = 0; m_ovf = 0; m_digit = '0; m_nib = '0;
      run = 0;
    end else begin
      logic [4:0] r;
      logic       chg;
      acc_t       a;
      if (m_valid && evt_ready) m_valid = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        a   = pend.pop_front();
        r   = decode(a.pat);
        chg = (m_hex[a.dig] != r[3:0]) || (m_dp[a.dig] != a.dp) || (m_ok[a.dig] != r[4]);
        m_hex[a.dig] = r[3:0];
        m_dp[a.dig]  = a.dp;
        m_ok[a.dig]  = r[4];
        if (chg) begin
          if (!m_valid) begin
            m_valid = 1; m_digit = 3'(a.dig); m_nib = r[3:0]; m_err = !r[4];
          end else begin
            m_ovf = 1;
          end
        end
      end
      if ($countones(dig_en) == 1) begin
        if (run > 0 && dig_en == prev_en && seg == prev_seg) run++;
        else run = 1;
        prev_en  = dig_en;
        prev_seg = seg;
        // Dwell reaches the stability threshold: result lands two edges later.
        if (run == S) begin
          a.due = cyc + 2;
          a.dig = 0;
          for (int i = 0; i < N; i++) if (dig_en[i]) a.dig = i;
          a.pat = seg[0:6];
          a.dp  = seg[7];
          pend.push_back(a);
        end
      end else begin
        run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic [4*N-1:0] eh;
      for (int i = 0; i < N; i++) eh[4*i +: 4] = m_hex[i];
      check("hex_out", 32'(hex_out), 32'(eh));
      check("dp_out", 32'(dp_out), 32'(m_dp));
      check("digit_ok", 32'(digit_ok), 32'(m_ok));
      check("evt_valid", 32'(evt_valid), 32'(m_valid));
      check("evt_digit", 32'(evt_digit), 32'(m_digit));
      check("evt_nibble", 32'(evt_nibble), 32'(m_nib));
      check("evt_err", 32'(evt_err), 32'(m_err));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic show(input int d, input logic [6:0] p, input logic dp, input int n);
    dig_en = '0;
    dig_en[d] = 1'b1;
    seg = {p, dp};
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    dig_en = '0;
    seg    = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hex", 32'(hex_out), 32'h0);
    check("reset_evt_valid", 32'(evt_valid), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    idle(2);

    for (int d = 0; d < 4; d++) show(d, pat_tab[d+1], 1'b0, 20);
    idle(4);
    check("scan_hex", 32'(hex_out), 32'h4321);
    check("scan_ok", 32'(digit_ok), 32'hF);
    check("scan_events", 32'(dut_evts), 32'd4);

    for (int d = 0; d < 4; d++) show(d, pat_tab[d+1], 1'b0, 20);
    idle(4);
    check("rescan_hex", 32'(hex_out), 32'h4321);
    check("rescan_events", 32'(dut_evts), 32'd4);

    show(2, 7'b0110001, 1'b0, 3);
    show(2, pat_tab[2], 1'b0, 10);
    check("glitch_early_hex", 32'(hex_out), 32'h4321);
    check("glitch_early_ok", 32'(digit_ok), 32'hF);
    show(2, pat_tab[2], 1'b0, 10);
    idle(2);
    check("glitch_hex", 32'(hex_out), 32'h4221);
    check("glitch_events", 32'(dut_evts), 32'd5);

    show(3, pat_tab[7], 1'b0, S - 1);
    idle(4);
    check("short_dwell_hex", 32'(hex_out), 32'h4221);
    show(3, pat_tab[7], 1'b0, S);
    idle(4);
    check("exact_dwell_hex", 32'(hex_out), 32'h7221);
    check("exact_dwell_events", 32'(dut_evts), 32'd6);

    evt_ready = 1'b0;
    show(1, 7'b0100100, 1'b0, 20);
    idle(4);
    check("err_valid", 32'(evt_valid), 32'h1);
    check("err_flag", 32'(evt_err), 32'h1);
    check("err_nibble", 32'(evt_nibble), 32'h0);
    check("err_digit", 32'(evt_digit), 32'h1);
    check("err_digit_ok", 32'(digit_ok), 32'hD);
    check("err_hex", 32'(hex_out), 32'h7201);
    evt_ready = 1'b1;
    @(negedge clk);
    dig_en = 4'b0011;
    seg    = {pat_tab[8], 1'b0};
    repeat (20) @(negedge clk);
    idle(4);
    check("multi_en_hex", 32'(hex_out), 32'h7201);
    check("multi_en_events", 32'(dut_evts), 32'd7);

    evt_ready = 1'b0;
    show(0, pat_tab[9], 1'b0, 20);
    show(0, pat_tab[10], 1'b0, 20);
    idle(4);
    check("ovf_held_nibble", 32'(evt_nibble), 32'h9);
    check("ovf_held_digit", 32'(evt_digit), 32'h0);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_hex", 32'(hex_out), 32'h720A);
    evt_ready = 1'b1;
    idle(3);
    check("ovf_drained", 32'(evt_valid), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h1);

    show(3, pat_tab[5], 1'b0, 8);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_hex", 32'(hex_out), 32'h0);
    check("midreset_ok", 32'(digit_ok), 32'h0);
    check("midreset_valid", 32'(evt_valid), 32'h0);
    check("midreset_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    show(3, pat_tab[5], 1'b1, 20);
    idle(4);
    check("post_reset_hex", 32'(hex_out), 32'h5000);
    check("post_reset_dp", 32'(dp_out), 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
